// File: rtl/mem_arbiter.sv
// Two-master to one-slave memory arbiter.
// Winners are forwarded to the slave combinationally in the cycle they are
// chosen. A losing request waits in a one-entry pending slot per master.
// Reads hold the arbiter in READ until the slave drops mem_rbusy.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 24
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] m0_addr,
    input  logic        m0_rstrb,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wmask,
    output logic [31:0] m0_rdata,
    output logic        m0_rbusy,
    input  logic [31:0] m1_addr,
    input  logic        m1_rstrb,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wmask,
    output logic [31:0] m1_rdata,
    output logic        m1_rbusy,
    output logic [31:0] mem_addr,
    output logic        mem_rstrb,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rbusy
);

    localparam logic [31:0] ADDR_MASK = (ADDR_WIDTH >= 32) ? 32'hFFFF_FFFF
                                        : ((32'h1 << ADDR_WIDTH) - 32'h1);

    typedef enum logic {IDLE, READ} state_t;

    state_t      state;
    logic        owner;
    logic        rr;
    logic [1:0]  pend_valid;
    logic [1:0]  pend_write;
    logic [31:0] pend_addr  [2];
    logic [31:0] pend_wdata [2];
    logic [3:0]  pend_wmask [2];
    logic [31:0] rdata_q    [2];

    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_wmask [2];
    logic [1:0]  fresh;

    logic [1:0]  busy;
    logic [1:0]  accept;
    logic        grant;
    logic        winner;
    logic        win_pend;
    logic        read_done;
    logic        w_write;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [3:0]  w_wmask;

    assign req_addr[0]  = m0_addr;
    assign req_addr[1]  = m1_addr;
    assign req_wdata[0] = m0_wdata;
    assign req_wdata[1] = m1_wdata;
    assign req_wmask[0] = m0_wmask;
    assign req_wmask[1] = m1_wmask;
    assign fresh[0]     = m0_rstrb || (m0_wmask != 4'h0);
    assign fresh[1]     = m1_rstrb || (m1_wmask != 4'h0);

    // Arbitration: pending requests beat fresh ones, ties go to rr, and the
    // chosen request is muxed straight onto the slave port.
    always_comb begin
        grant     = 1'b0;
        winner    = rr;
        win_pend  = 1'b0;
        busy      = 2'b00;
        accept    = 2'b00;
        w_write   = 1'b0;
        w_addr    = 32'h0;
        w_wdata   = 32'h0;
        w_wmask   = 4'h0;
        read_done = resetn && (state == READ) && !mem_rbusy;
        if (resetn) begin
            if (state == IDLE) begin
                if (pend_valid != 2'b00) begin
                    grant    = 1'b1;
                    win_pend = 1'b1;
                    winner   = (pend_valid == 2'b11) ? rr : pend_valid[1];
                end
                for (int i = 0; i < 2; i++) begin
                    busy[i] = pend_valid[i] &&
                              !(grant && (winner == 1'(i)) && pend_write[i]);
                end
            end else begin
                busy        = pend_valid;
                busy[owner] = mem_rbusy;
            end
            for (int i = 0; i < 2; i++) begin
                accept[i] = fresh[i] && !busy[i];
            end
            if ((state == IDLE) && !win_pend && (accept != 2'b00)) begin
                grant  = 1'b1;
                winner = (accept == 2'b11) ? rr : accept[1];
            end
        end
        if (grant) begin
            if (win_pend) begin
                w_write = pend_write[winner];
                w_addr  = pend_addr[winner];
                w_wdata = pend_wdata[winner];
                w_wmask = pend_wmask[winner];
            end else begin
                w_write = (req_wmask[winner] != 4'h0);
                w_addr  = req_addr[winner];
                w_wdata = req_wdata[winner];
                w_wmask = req_wmask[winner];
            end
        end
    end

    assign mem_addr  = grant ? (w_addr & ADDR_MASK) : 32'h0;
    assign mem_wdata = grant ? w_wdata : 32'h0;
    assign mem_wmask = (grant && w_write) ? w_wmask : 4'h0;
    assign mem_rstrb = grant && !w_write;
    assign m0_rbusy  = busy[0];
    assign m1_rbusy  = busy[1];
    assign m0_rdata  = (read_done && !owner) ? mem_rdata : rdata_q[0];
    assign m1_rdata  = (read_done && owner)  ? mem_rdata : rdata_q[1];

    // State, round-robin pointer, read capture and pending-slot bookkeeping.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            owner      <= 1'b0;
            rr         <= 1'b0;
            pend_valid <= 2'b00;
            pend_write <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                pend_addr[i]  <= 32'h0;
                pend_wdata[i] <= 32'h0;
                pend_wmask[i] <= 4'h0;
                rdata_q[i]    <= 32'h0;
            end
        end else begin
            if (state == IDLE) begin
                if (grant) begin
                    rr <= ~winner;
                    if (!w_write) begin
                        state <= READ;
                        owner <= winner;
                    end
                end
            end else if (read_done) begin
                rdata_q[owner] <= mem_rdata;
                state          <= IDLE;
            end
            for (int i = 0; i < 2; i++) begin
                if (accept[i] && !(grant && !win_pend && (winner == 1'(i)))) begin
                    pend_valid[i] <= 1'b1;
                    pend_write[i] <= (req_wmask[i] != 4'h0);
                    pend_addr[i]  <= req_addr[i];
                    pend_wdata[i] <= req_wdata[i];
                    pend_wmask[i] <= req_wmask[i];
                end else if (grant && win_pend && (winner == 1'(i))) begin
                    pend_valid[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a small slave model with programmable read
// latency, and a scoreboard of expected slave transactions checked on every
// cycle that the arbiter drives the slave port.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m0_rdata;
    logic        m0_rstrb = 1'b0, m0_rbusy;
    logic [3:0]  m0_wmask = '0;
    logic [31:0] m1_addr = '0, m1_wdata = '0, m1_rdata;
    logic        m1_rstrb = 1'b0, m1_rbusy;
    logic [3:0]  m1_wmask = '0;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_rstrb, mem_rbusy;
    logic [3:0]  mem_wmask;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } txn_t;

    txn_t        exp_q[$];
    int          compared = 0;
    int          mismatched = 0;
    int          slave_latency = 0;
    int          busy_cnt = 0;
    logic [31:0] slave_addr = '0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(24)) dut (
        .clk(clk), .resetn(resetn),
        .m0_addr(m0_addr), .m0_rstrb(m0_rstrb), .m0_wdata(m0_wdata),
        .m0_wmask(m0_wmask), .m0_rdata(m0_rdata), .m0_rbusy(m0_rbusy),
        .m1_addr(m1_addr), .m1_rstrb(m1_rstrb), .m1_wdata(m1_wdata),
        .m1_wmask(m1_wmask), .m1_rdata(m1_rdata), .m1_rbusy(m1_rbusy),
        .mem_addr(mem_addr), .mem_rstrb(mem_rstrb), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .mem_rbusy(mem_rbusy)
    );

    function automatic logic [31:0] slave_data(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEAD_BEEF;
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic txn_t rd(input logic [31:0] a);
        txn_t t;
        t.write = 1'b0; t.addr = a; t.wdata = 32'h0; t.wmask = 4'h0;
        return t;
    endfunction

    function automatic txn_t wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        txn_t t;
        t.write = 1'b1; t.addr = a; t.wdata = d; t.wmask = m;
        return t;
    endfunction

    // Slave model: latch the read address, stay busy for slave_latency cycles.
    always @(posedge clk) begin
        if (mem_rstrb) begin
            slave_addr <= mem_addr;
            busy_cnt   <= slave_latency;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end
    assign mem_rbusy = (busy_cnt != 0);
    assign mem_rdata = slave_data(slave_addr);

    // Scoreboard: every slave-side transaction must match the next expected one.
    always @(negedge clk) begin
        txn_t got, e;
        if (resetn === 1'b1 && (mem_rstrb === 1'b1 || mem_wmask !== 4'h0)) begin
            got.write = (mem_wmask != 4'h0);
            got.addr  = mem_addr;
            got.wdata = got.write ? mem_wdata : 32'h0;
            got.wmask = mem_wmask;
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL unexpected_txn at %0t: got w=%0d addr=%h wdata=%h wmask=%h, required none",
                         $time, got.write, got.addr, got.wdata, got.wmask);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    mismatched++;
                    $display("[TB] FAIL txn_order at %0t: got w=%0d addr=%h wdata=%h wmask=%h, required w=%0d addr=%h wdata=%h wmask=%h",
                             $time, got.write, got.addr, got.wdata, got.wmask,
                             e.write, e.addr, e.wdata, e.wmask);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
        m0_rstrb = 1'b0; m0_wmask = 4'h0;
        m1_rstrb = 1'b0; m1_wmask = 4'h0;
    endtask

    task automatic test_reset();
        logic [72:0] slv;
        logic [65:0] mst;
        resetn = 1'b0;
        m0_addr = 32'h1234; m0_rstrb = 1'b1;
        m1_addr = 32'h5678; m1_wdata = 32'hFFFF; m1_wmask = 4'hF;
        #3;
        slv = {mem_rstrb, mem_wmask, mem_addr, mem_wdata};
        compared++;
        if (slv !== 73'h0) begin mismatched++; $display("[TB] FAIL reset_slave_port: got %h, required 0", slv); end
        mst = {m0_rbusy, m1_rbusy, m0_rdata, m1_rdata};
        compared++;
        if (mst !== 66'h0) begin mismatched++; $display("[TB] FAIL reset_master_port: got %h, required 0", mst); end
        m0_rstrb = 1'b0; m1_wmask = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_simultaneous();
        slave_latency = 0;
        next_cycle();
        m0_addr = 32'h10; m0_rstrb = 1'b1; m1_addr = 32'h20; m1_rstrb = 1'b1;
        exp_q.push_back(rd(32'h10)); exp_q.push_back(rd(32'h20));
        @(negedge clk);
        compared++;
        if (m1_rbusy !== 1'b0) begin mismatched++; $display("[TB] FAIL sim_c0_m1_rbusy: got %b, required 0", m1_rbusy); end
        next_cycle();
        @(negedge clk);
        compared++;
        if (m1_rbusy !== 1'b1) begin mismatched++; $display("[TB] FAIL sim_c1_m1_rbusy: got %b, required 1", m1_rbusy); end
        compared++;
        if (m0_rdata !== slave_data(32'h10)) begin mismatched++; $display("[TB] FAIL sim_m0_rdata: got %h, required %h", m0_rdata, slave_data(32'h10)); end
        next_cycle();
        @(negedge clk);
        compared++;
        if ({mem_rstrb, mem_addr, m1_rbusy} !== {1'b1, 32'h20, 1'b1}) begin
            mismatched++; $display("[TB] FAIL sim_c2_issue: got rstrb=%b addr=%h rbusy=%b, required 1 00000020 1", mem_rstrb, mem_addr, m1_rbusy);
        end
        next_cycle();
        @(negedge clk);
        compared++;
        if ({m1_rbusy, m1_rdata} !== {1'b0, slave_data(32'h20)}) begin
            mismatched++; $display("[TB] FAIL sim_c3_m1_done: got rbusy=%b rdata=%h, required 0 %h", m1_rbusy, m1_rdata, slave_data(32'h20));
        end
        next_cycle();
    endtask

    task automatic test_solo_read();
        slave_latency = 0;
        next_cycle();
        m0_addr = 32'h100; m0_rstrb = 1'b1;
        exp_q.push_back(rd(32'h100));
        @(negedge clk);
        compared++;
        if ({mem_rstrb, m0_rbusy} !== 2'b10) begin mismatched++; $display("[TB] FAIL solo_c0: got rstrb=%b rbusy=%b, required 1 0", mem_rstrb, m0_rbusy); end
        next_cycle();
        @(negedge clk);
        compared++;
        if ({m0_rbusy, m0_rdata} !== {1'b0, 32'hDEAD_BEEF}) begin
            mismatched++; $display("[TB] FAIL solo_c1: got rbusy=%b rdata=%h, required 0 deadbeef", m0_rbusy, m0_rdata);
        end
        next_cycle();
        @(negedge clk);
        compared++;
        if ({mem_rstrb, m0_rdata} !== {1'b0, 32'hDEAD_BEEF}) begin
            mismatched++; $display("[TB] FAIL solo_hold: got rstrb=%b rdata=%h, required 0 deadbeef", mem_rstrb, m0_rdata);
        end
    endtask

    task automatic test_addr_width();
        slave_latency = 0;
        next_cycle();
        m1_addr = 32'hAB00_0200; m1_rstrb = 1'b1;
        m0_addr = 32'hFFFF_FFF0; m0_wdata = 32'hCAFE_F00D; m0_wmask = 4'hF;
        exp_q.push_back(rd(32'h0000_0200));
        exp_q.push_back(wr(32'h00FF_FFF0, 32'hCAFE_F00D, 4'hF));
        @(negedge clk);
        compared++;
        if (mem_addr !== 32'h0000_0200) begin mismatched++; $display("[TB] FAIL addr_trunc: got %h, required 00000200", mem_addr); end
        next_cycle();
        @(negedge clk);
        compared++;
        if ({m0_rbusy, m1_rdata} !== {1'b1, slave_data(32'h200)}) begin
            mismatched++; $display("[TB] FAIL aw_c1: got m0_rbusy=%b m1_rdata=%h, required 1 %h", m0_rbusy, m1_rdata, slave_data(32'h200));
        end
        next_cycle();
        @(negedge clk);
        compared++;
        if ({mem_wmask, mem_addr, m0_rbusy} !== {4'hF, 32'h00FF_FFF0, 1'b0}) begin
            mismatched++; $display("[TB] FAIL aw_pend_write: got wmask=%h addr=%h rbusy=%b, required f 00fffff0 0", mem_wmask, mem_addr, m0_rbusy);
        end
        m0_wdata = 32'h0;
    endtask

    task automatic test_busy_slave();
        slave_latency = 5;
        next_cycle();
        m1_addr = 32'h300; m1_rstrb = 1'b1;
        exp_q.push_back(rd(32'h300));
        for (int c = 1; c <= 5; c++) begin
            next_cycle();
            if (c == 2) begin
                m0_addr = 32'h40; m0_wdata = 32'h1234; m0_wmask = 4'b0011;
                exp_q.push_back(wr(32'h40, 32'h1234, 4'b0011));
            end
            @(negedge clk);
            compared++;
            if ({m1_rbusy, mem_wmask, mem_rstrb} !== {1'b1, 4'h0, 1'b0}) begin
                mismatched++; $display("[TB] FAIL busy_c%0d: got m1_rbusy=%b wmask=%h rstrb=%b, required 1 0 0", c, m1_rbusy, mem_wmask, mem_rstrb);
            end
            if (c >= 2) begin
                compared++;
                if (m0_rbusy !== (c > 2)) begin mismatched++; $display("[TB] FAIL busy_m0_rbusy_c%0d: got %b, required %b", c, m0_rbusy, (c > 2)); end
            end
        end
        next_cycle();
        @(negedge clk);
        compared++;
        if ({m1_rbusy, m1_rdata, mem_wmask, m0_rbusy} !== {1'b0, slave_data(32'h300), 4'h0, 1'b1}) begin
            mismatched++; $display("[TB] FAIL busy_complete: got m1_rbusy=%b rdata=%h wmask=%h m0_rbusy=%b, required 0 %h 0 1",
                                   m1_rbusy, m1_rdata, mem_wmask, m0_rbusy, slave_data(32'h300));
        end
        next_cycle();
        @(negedge clk);
        compared++;
        if ({mem_wmask, mem_wdata, m0_rbusy} !== {4'b0011, 32'h1234, 1'b0}) begin
            mismatched++; $display("[TB] FAIL busy_write_issue: got wmask=%h wdata=%h rbusy=%b, required 3 00001234 0", mem_wmask, mem_wdata, m0_rbusy);
        end
        next_cycle();
        m0_wdata = 32'h0;
    endtask

    task automatic test_ignored_strobe();
        slave_latency = 3;
        next_cycle();
        m0_addr = 32'h500; m0_rstrb = 1'b1;
        exp_q.push_back(rd(32'h500));
        next_cycle();
        m1_addr = 32'h600; m1_rstrb = 1'b1;
        exp_q.push_back(rd(32'h600));
        @(negedge clk);
        compared++;
        if (m1_rbusy !== 1'b0) begin mismatched++; $display("[TB] FAIL ign_capture_rbusy: got %b, required 0", m1_rbusy); end
        for (int c = 2; c <= 3; c++) begin
            next_cycle();
            m1_addr = 32'h666; m1_rstrb = 1'b1;
            @(negedge clk);
            compared++;
            if (m1_rbusy !== 1'b1) begin mismatched++; $display("[TB] FAIL ign_rbusy_c%0d: got %b, required 1", c, m1_rbusy); end
        end
        next_cycle();
        @(negedge clk);
        compared++;
        if (m0_rdata !== slave_data(32'h500)) begin mismatched++; $display("[TB] FAIL ign_m0_rdata: got %h, required %h", m0_rdata, slave_data(32'h500)); end
        repeat (12) next_cycle();
        compared++;
        if (exp_q.size() != 0) begin mismatched++; $display("[TB] FAIL ign_drain: got %0d outstanding, required 0", exp_q.size()); end
        compared++;
        if (m1_rdata !== slave_data(32'h600)) begin mismatched++; $display("[TB] FAIL ign_m1_rdata: got %h, required %h", m1_rdata, slave_data(32'h600)); end
    endtask

    task automatic test_reset_mid_read();
        logic [72:0] slv;
        logic [65:0] mst;
        slave_latency = 10;
        next_cycle();
        m1_addr = 32'h700; m1_rstrb = 1'b1;
        exp_q.push_back(rd(32'h700));
        next_cycle();
        m0_addr = 32'h710; m0_rstrb = 1'b1;
        next_cycle();
        @(negedge clk);
        compared++;
        if ({m0_rbusy, m1_rbusy} !== 2'b11) begin mismatched++; $display("[TB] FAIL rmr_pre_busy: got %b%b, required 11", m0_rbusy, m1_rbusy); end
        next_cycle();
        resetn = 1'b0;
        #2;
        slv = {mem_rstrb, mem_wmask, mem_addr, mem_wdata};
        mst = {m0_rbusy, m1_rbusy, m0_rdata, m1_rdata};
        compared++;
        if ({slv, mst} !== 139'h0) begin mismatched++; $display("[TB] FAIL rmr_outputs: got slave=%h master=%h, required 0", slv, mst); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        repeat (15) next_cycle();
        compared++;
        if ({m0_rdata, m1_rdata, m0_rbusy, m1_rbusy} !== 66'h0) begin
            mismatched++; $display("[TB] FAIL rmr_after: got m0_rdata=%h m1_rdata=%h rbusy=%b%b, required 0", m0_rdata, m1_rdata, m0_rbusy, m1_rbusy);
        end
        compared++;
        if (exp_q.size() != 0) begin mismatched++; $display("[TB] FAIL rmr_drain: got %0d outstanding, required 0", exp_q.size()); end
    endtask

    task automatic test_fairness();
        int n0 = 0, n1 = 0;
        slave_latency = 1;
        for (int c = 0; c < 80; c++) begin
            next_cycle();
            if (!m0_rbusy && n0 < 6) begin
                m0_addr = 32'h1000 + 32'(n0 * 4); m0_rstrb = 1'b1;
                exp_q.push_back(rd(m0_addr)); n0++;
            end
            if (!m1_rbusy && n1 < 6) begin
                m1_addr = 32'h2000 + 32'(n1 * 4); m1_rstrb = 1'b1;
                exp_q.push_back(rd(m1_addr)); n1++;
            end
        end
        compared++;
        if (exp_q.size() != 0) begin mismatched++; $display("[TB] FAIL fair_drain: got %0d outstanding, required 0", exp_q.size()); end
        compared++;
        if ({m0_rdata, m1_rdata} !== {slave_data(32'h1014), slave_data(32'h2014)}) begin
            mismatched++; $display("[TB] FAIL fair_rdata: got %h %h, required %h %h", m0_rdata, m1_rdata, slave_data(32'h1014), slave_data(32'h2014));
        end
    endtask

    initial begin
        test_reset();
        test_simultaneous();
        test_solo_read();
        test_addr_width();
        test_busy_slave();
        test_ignored_strobe();
        test_reset_mid_read();
        test_fairness();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 24, meaning the number of address bits forwarded to the slave (upper bits are zero).
REQ-002 SHALL have ports clk (input, 1): single clock; all state on rising edge.
REQ-003 SHALL have resetn (input, 1): reset, asynchronous and active-low.
REQ-004 SHALL have, per master N in {0,1}:
- mN_addr (in, 32)
- mN_rstrb (in, 1): read request pulse.
- mN_wdata (in, 32)
- mN_wmask (in, 4): nonzero = write request pulse.
- mN_rdata (out, 32)
- mN_rbusy (out, 1): request not yet serviced.
REQ-005 SHALL have slave ports:
- mem_addr (out, 32)
- mem_rstrb (out, 1)
- mem_wdata (out, 32)
- mem_wmask (out, 4)
- mem_rdata (in, 32)
- mem_rbusy (in, 1): slave read in progress.

Function
REQ-006 Request SHALL be one-cycle pulse: rstrb=1 (read) or wmask!=0 (write); rstrb with wmask!=0 is treated as write.
REQ-007 Strobes from a master while its rbusy=1 SHALL be ignored.
REQ-008 States SHALL be IDLE and READ, with registered owner (0/1), one pending slot per master (valid, kind, addr, wdata, wmask), and round-robin pointer rr.
REQ-009 In IDLE, candidates SHALL be pending requests plus fresh pulses. Arbitration order:
- any pending beats fresh;
- two of the same class: master rr wins, then rr <= other master.
- Every grant sets rr to the non-granted master.
REQ-010 Winner SHALL be issued combinationally in the same cycle (mem_addr/wdata/wmask/rstrb from winner), giving zero added latency without contention.
REQ-011 Fresh loser SHALL be captured into its pending slot.
- Its rbusy=1 from the next cycle until the issue cycle (write) or completion cycle (read).
REQ-012 Write issue SHALL leave the state at IDLE.
- Read issue: state <= READ, owner <= winner.
REQ-013 In READ, mem_rstrb and mem_wmask SHALL be 0.
- Owner rbusy = mem_rbusy.
- Fresh requests from the non-owner are captured pending, with rbusy=1 next cycle.
REQ-014 Completion cycle SHALL be the first READ cycle with mem_rbusy=0. In that cycle:
- owner rdata = mem_rdata, rbusy=0;
- mem_rdata is captured into owner's rdata register;
- state <= IDLE; no issue that cycle.
REQ-015 mN_rdata SHALL equal the captured register outside its completion cycle, held until its next read completes.
REQ-016 mem_addr SHALL be zero-extended from ADDR_WIDTH bits.
- Outputs in IDLE with no candidate: mem_rstrb=0, mem_wmask=0, mem_addr/mem_wdata = 0.
REQ-017 A pending write issued from IDLE SHALL deassert that master's rbusy in the issue cycle.

Reset
REQ-018 resetn=0 SHALL asynchronously force:
- state=IDLE, both pending slots invalid, rr=0, owner=0;
- mN_rdata=0, mN_rbusy=0, mem_rstrb=0, mem_wmask=0, mem_addr=0, mem_wdata=0.
REQ-019 Reset during READ SHALL abort the read; later slave data is discarded and no master sees a completion.

Verification
REQ-020 Solo read:
- Stimulus: m0 read addr 0x100; slave rbusy=0; returns 0xDEADBEEF.
- Response: mem_rstrb same cycle, m0_rbusy never 1, m0_rdata=0xDEADBEEF next cycle and held.
REQ-021 Simultaneous reads, rr=0:
- Stimulus: m0 0x10, m1 0x20.
- Response: m0 issued cycle 0, m1_rbusy=1 from cycle 1, m1 issued cycle 2 (after IDLE), each rdata correct.
REQ-022 Busy slave:
- Stimulus: mem_rbusy=1 for 5 cycles after m1 read.
- Response: m1_rbusy=1 those 5 cycles; completion in cycle 6.
- A m0 write (wmask=4'b0011, wdata=0x1234) arriving in cycle 2 issues in the cycle after completion with wmask=4'b0011.
REQ-023 Fairness:
- Stimulus: both masters strobe reads continuously, honoring rbusy.
- Response: grants alternate 0,1,0,1…; no master waits more than one transaction.
REQ-024 Reset mid-read:
- Stimulus: resetn=0 in READ with m0 pending.
- Response: all outputs 0 immediately; after release, no spurious mem_rstrb and m0_rdata=0.
REQ-025 Ignored strobe:
- Stimulus: m1 strobes again while m1_rbusy=1.
- Response: exactly one m1 transaction reaches the slave.
